fact_dispatcher: RTL
====================

// Module: fact_dispatcher
// PURPOSE
// Job scheduler for the four memory-mapped factorial accelerators (fact0..fact3).
// Accepts factorial jobs on a valid/ready request port and launches each on a free accelerator, round-robin.
// Collects done/result/error from each accelerator and returns tagged results on a valid/ready response port.
// Sits between the CPU-side job interface and the accelerator bank.
// PARAMETERS
// NUM_FACT     4    number of accelerators managed (unit index width UW = $clog2(NUM_FACT))
// N_W          4    operand width (n)
// RES_W        32   result width
// TAG_W        4    job tag width, returned unchanged with the result
// TIMEOUT_CYC  255  max RUN cycles before the job is aborted with error
// PORTS
// clk          in   1              clock, all state on rising edge
// rst_n        in   1              asynchronous active-low reset
// req_valid    in   1              job request valid
// req_ready    out  1              dispatcher can accept a job this cycle
// req_n        in   N_W            factorial operand
// req_tag      in   TAG_W          caller tag
// fact_go      out  NUM_FACT       per-unit start, one-cycle pulse
// fact_n       out  NUM_FACT*N_W   per-unit operand, held stable from go until done
// fact_done    in   NUM_FACT       per-unit done level (unit clears it on go)
// fact_err     in   NUM_FACT       per-unit error, valid with done
// fact_result  in   NUM_FACT*RES_W per-unit result, valid with done
// rsp_valid    out  1              response valid
// rsp_ready    in   1              consumer accepts response
// rsp_result   out  RES_W          result (0 on error)
// rsp_tag      out  TAG_W          tag of the job
// rsp_err      out  1              accelerator error or timeout
// rsp_unit     out  UW             unit that executed the job
// busy_mask    out  NUM_FACT       1 = unit not IDLE
// BEHAVIOUR
// - Reset: all units IDLE; all outputs 0; both rr pointers 0; response register empty. Jobs in flight at reset are dropped.
// - Per-unit FSM: IDLE -> LAUNCH (1 cycle, go=1) -> RUN -> DONE -> IDLE.
// - req_ready = any unit IDLE; it depends on registered state only, never on req_valid.
// - Accept on req_valid && req_ready at edge T:
//   - Dispatch pointer picks the first IDLE unit at or after it, wrapping.
//   - At T the unit latches n/tag and enters LAUNCH, so go is high during cycle T+1.
//   - The pointer moves to the picked unit + 1 (mod NUM_FACT).
// - fact_done is ignored in LAUNCH and sampled only in RUN. In RUN, done=1 -> DONE, latching result/err.
// - RUN counter reaches TIMEOUT_CYC with no done -> DONE with err=1, result 0. The late done is then ignored.
// - Response register loads from a DONE unit when it is empty, or is popped (rsp_valid && rsp_ready) in the same cycle.
//   - A separate rr pointer picks among DONE units, so no starvation.
//   - Loaded unit -> IDLE next cycle and is dispatchable then.
// - rsp_valid holds until rsp_ready. Payload stays stable while rsp_valid && !rsp_ready.
// - Throughput: pop and reload in the same cycle gives one response per cycle.
// - Simultaneous accept + completion: independent; a unit freed in cycle C is dispatchable at C+1, never at C.
// - err=1 forces rsp_result=0.
// - All units busy: req_ready=0 and req_* are ignored.
// - Minimum latency: accept T, go T+1, done seen T+2 (when the unit is done next cycle), rsp_valid T+3.
// STRUCTURE
// - fact_pkg holds:
//   - N_W and RES_W defaults
//   - the unit state enum {IDLE, LAUNCH, RUN, DONE}
//   - typedef job_t {n, tag}
// - Sub-module rr_arbiter #(N) (req mask, pointer -> one-hot grant + index), instantiated twice: dispatch and response.
// - Per-unit FSM, timeout counter and latched job/result are a generate loop in this module.
// TESTING
// - Single job n=5, tag=3, unit done 4 cycles after go -> go[0] pulse once; rsp_result=0x78, tag=3, unit=0, err=0.
// - Four back-to-back jobs, no stall -> go on units 0,1,2,3 in consecutive cycles. Fifth request sees req_ready=0 until a response pops.
// - n=12 -> rsp_result=0x1C8CFC00. n=13 with fact_err=1 -> rsp_err=1, rsp_result=0.
// - Units 1 and 2 finish the same cycle; rsp_ready held 0 for 5 cycles -> payload of unit 1 stable, then unit 2 on the next cycle. Units stay busy until loaded.
// - Unit never raises done -> after 255 RUN cycles rsp_err=1 and the unit returns to IDLE. A done arriving later produces no response.
// - rst_n asserted while 3 jobs run -> rsp_valid, go and busy_mask all 0 immediately. After release, a new job dispatches to unit 0.

Source files
------------

// File: rtl/fact_pkg.sv
// rtl/fact_pkg.sv - shared types, defaults and helpers for the factorial job dispatcher
package fact_pkg;

  localparam int N_W_DEF   = 4;
  localparam int RES_W_DEF = 32;
  localparam int TAG_W_DEF = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LAUNCH = 2'd1,
    ST_RUN    = 2'd2,
    ST_DONE   = 2'd3
  } unit_state_e;

  typedef struct packed {
    logic [N_W_DEF-1:0]   n;
    logic [TAG_W_DEF-1:0] tag;
  } job_t;

  // Index width that stays at least one bit for single-entry banks.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - round-robin pick of the first requester at or after ptr, wrapping
module rr_arbiter
  import fact_pkg::*;
#(
  parameter int N = 4
) (
  input  logic [N-1:0]               req,
  input  logic [idx_width(N)-1:0]    ptr,
  output logic [N-1:0]               grant,
  output logic [idx_width(N)-1:0]    grant_idx,
  output logic                       grant_any
);

  localparam int IW = idx_width(N);

  logic [IW-1:0] cand;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    grant_any = 1'b0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      cand = IW'((int'(ptr) + i) % N);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant[cand] = 1'b1;
        grant_idx   = cand;
      end
    end
  end

endmodule

// File: rtl/fact_dispatcher.sv
// rtl/fact_dispatcher.sv - launches factorial jobs on free accelerators round-robin
// and returns tagged results through a one-entry response register.
module fact_dispatcher
  import fact_pkg::*;
#(
  parameter int NUM_FACT    = 4,
  parameter int N_W         = N_W_DEF,
  parameter int RES_W       = RES_W_DEF,
  parameter int TAG_W       = TAG_W_DEF,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            req_valid,
  output logic                            req_ready,
  input  logic [N_W-1:0]                  req_n,
  input  logic [TAG_W-1:0]                req_tag,
  output logic [NUM_FACT-1:0]             fact_go,
  output logic [NUM_FACT*N_W-1:0]         fact_n,
  input  logic [NUM_FACT-1:0]             fact_done,
  input  logic [NUM_FACT-1:0]             fact_err,
  input  logic [NUM_FACT*RES_W-1:0]       fact_result,
  output logic                            rsp_valid,
  input  logic                            rsp_ready,
  output logic [RES_W-1:0]                rsp_result,
  output logic [TAG_W-1:0]                rsp_tag,
  output logic                            rsp_err,
  output logic [idx_width(NUM_FACT)-1:0]  rsp_unit,
  output logic [NUM_FACT-1:0]             busy_mask
);

  localparam int UW = idx_width(NUM_FACT);
  localparam int CW = idx_width(TIMEOUT_CYC + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT_CYC - 1);

  logic [NUM_FACT-1:0]            idle_mask;
  logic [NUM_FACT-1:0]            done_mask;
  logic [NUM_FACT-1:0]            disp_grant;
  logic [NUM_FACT-1:0]            rsp_grant;
  logic [UW-1:0]                  disp_idx;
  logic [UW-1:0]                  rsp_idx;
  logic                           disp_any;
  logic                           rsp_any;
  logic                           accept;
  logic                           rsp_load;
  logic [NUM_FACT-1:0][RES_W-1:0] unit_res;
  logic [NUM_FACT-1:0][TAG_W-1:0] unit_tag;
  logic [NUM_FACT-1:0]            unit_err;

  logic [UW-1:0]    disp_ptr_q, disp_ptr_d;
  logic [UW-1:0]    rsp_ptr_q, rsp_ptr_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [RES_W-1:0] rsp_result_q, rsp_result_d;
  logic [TAG_W-1:0] rsp_tag_q, rsp_tag_d;
  logic             rsp_err_q, rsp_err_d;
  logic [UW-1:0]    rsp_unit_q, rsp_unit_d;

  function automatic logic [UW-1:0] wrap_inc(input logic [UW-1:0] v);
    return (int'(v) == NUM_FACT - 1) ? '0 : v + 1'b1;
  endfunction

  rr_arbiter #(.N(NUM_FACT)) u_disp_arb (
    .req       (idle_mask),
    .ptr       (disp_ptr_q),
    .grant     (disp_grant),
    .grant_idx (disp_idx),
    .grant_any (disp_any)
  );

  rr_arbiter #(.N(NUM_FACT)) u_rsp_arb (
    .req       (done_mask),
    .ptr       (rsp_ptr_q),
    .grant     (rsp_grant),
    .grant_idx (rsp_idx),
    .grant_any (rsp_any)
  );

  // Readiness comes only from unit state so a request never sees a combinational loop.
  assign req_ready = disp_any;
  assign accept    = req_valid && disp_any;
  assign rsp_load  = rsp_any && (!rsp_valid_q || rsp_ready);

  for (genvar i = 0; i < NUM_FACT; i++) begin : g_unit
    unit_state_e      st_q, st_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [N_W-1:0]   n_q, n_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [RES_W-1:0] res_q, res_d;
    logic             err_q, err_d;
    logic             go_q, go_d;

    always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      n_d   = n_q;
      tag_d = tag_q;
      res_d = res_q;
      err_d = err_q;
      go_d  = 1'b0;
      case (st_q)
        ST_IDLE: begin
          if (accept && disp_grant[i]) begin
            st_d  = ST_LAUNCH;
            n_d   = req_n;
            tag_d = req_tag;
            go_d  = 1'b1;
          end
        end
        ST_LAUNCH: begin
          st_d  = ST_RUN;
          cnt_d = '0;
        end
        ST_RUN: begin
          if (fact_done[i]) begin
            st_d  = ST_DONE;
            err_d = fact_err[i];
            res_d = fact_err[i] ? '0 : fact_result[i*RES_W +: RES_W];
          end else if (cnt_q == TMO_LAST) begin
            st_d  = ST_DONE;
            err_d = 1'b1;
            res_d = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_DONE: begin
          if (rsp_load && rsp_grant[i]) st_d = ST_IDLE;
        end
        default: st_d = ST_IDLE;
      endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        st_q  <= ST_IDLE;
        cnt_q <= '0;
        n_q   <= '0;
        tag_q <= '0;
        res_q <= '0;
        err_q <= 1'b0;
        go_q  <= 1'b0;
      end else begin
        st_q  <= st_d;
        cnt_q <= cnt_d;
        n_q   <= n_d;
        tag_q <= tag_d;
        res_q <= res_d;
        err_q <= err_d;
        go_q  <= go_d;
      end
    end

    assign idle_mask[i]             = (st_q == ST_IDLE);
    assign done_mask[i]             = (st_q == ST_DONE);
    assign busy_mask[i]             = (st_q != ST_IDLE);
    assign fact_go[i]               = go_q;
    assign fact_n[i*N_W +: N_W]     = n_q;
    assign unit_res[i]              = res_q;
    assign unit_tag[i]              = tag_q;
    assign unit_err[i]              = err_q;
  end

  // A pop and a reload in the same cycle keep the register full for back-to-back responses.
  always_comb begin
    rsp_valid_d  = rsp_valid_q;
    rsp_result_d = rsp_result_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    rsp_unit_d   = rsp_unit_q;
    if (rsp_load) begin
      rsp_valid_d  = 1'b1;
      rsp_result_d = unit_res[rsp_idx];
      rsp_tag_d    = unit_tag[rsp_idx];
      rsp_err_d    = unit_err[rsp_idx];
      rsp_unit_d   = rsp_idx;
    end else if (rsp_ready) begin
      rsp_valid_d  = 1'b0;
    end
    disp_ptr_d = accept   ? wrap_inc(disp_idx) : disp_ptr_q;
    rsp_ptr_d  = rsp_load ? wrap_inc(rsp_idx)  : rsp_ptr_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_ptr_q   <= '0;
      rsp_ptr_q    <= '0;
      rsp_valid_q  <= 1'b0;
      rsp_result_q <= '0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
      rsp_unit_q   <= '0;
    end else begin
      disp_ptr_q   <= disp_ptr_d;
      rsp_ptr_q    <= rsp_ptr_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
      rsp_unit_q   <= rsp_unit_d;
    end
  end

  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;
  assign rsp_unit   = rsp_unit_q;

endmodule
